// File: rtl/mu_seq_pkg.sv
// Shared types and default sizes for the MatrixUnit job sequencer.
package mu_seq_pkg;

  localparam int NUM_PARAMS_DEF = 8;
  localparam int PARAM_W_DEF    = 32;
  localparam int BEAT_W_DEF     = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    STREAM,
    WAIT_DONE
  } mu_seq_state_e;

endpackage

// File: rtl/mu_param_serializer.sv
// Captures a job's parameter words in parallel and presents them one at a time
// (word 0 first) on a registered valid/ready port.
module mu_param_serializer
  import mu_seq_pkg::*;
#(
  parameter int NUM_PARAMS = NUM_PARAMS_DEF,
  parameter int PARAM_W    = PARAM_W_DEF
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          load,
  input  logic                          flush,
  input  logic [NUM_PARAMS*PARAM_W-1:0] par_in,
  output logic                          vld,
  input  logic                          rdy,
  output logic [PARAM_W-1:0]            dat,
  output logic                          last
);

  localparam int IDX_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PARAMS - 1);

  logic [NUM_PARAMS*PARAM_W-1:0] par_reg;
  logic [IDX_W-1:0]              idx_reg;
  logic                          vld_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_reg <= '0;
    end else if (load) begin
      par_reg <= par_in;
    end
  end

  // vld drops in the cycle after the last word is taken, so every word spends at least one cycle on the port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_reg <= 1'b0;
      idx_reg <= '0;
    end else if (flush) begin
      vld_reg <= 1'b0;
      idx_reg <= '0;
    end else if (load) begin
      vld_reg <= 1'b1;
      idx_reg <= '0;
    end else if (vld_reg && rdy) begin
      if (idx_reg == LAST_IDX) begin
        vld_reg <= 1'b0;
        idx_reg <= '0;
      end else begin
        idx_reg <= idx_reg + IDX_W'(1);
      end
    end
  end

  assign vld  = vld_reg;
  assign last = (idx_reg == LAST_IDX);
  assign dat  = vld_reg ? par_reg[idx_reg*PARAM_W +: PARAM_W] : '0;

endmodule

// File: rtl/mu_job_sequencer.sv
// Runs one MatrixUnit job per request: parameter load, start, gated output
// stream towards Garnet, then the done handshake and a completion pulse.
module mu_job_sequencer
  import mu_seq_pkg::*;
#(
  parameter int NUM_PARAMS = NUM_PARAMS_DEF,
  parameter int PARAM_W    = PARAM_W_DEF,
  parameter int BEAT_W     = BEAT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          job_start,
  input  logic                          job_abort,
  input  logic [NUM_PARAMS*PARAM_W-1:0] job_params,
  input  logic [BEAT_W-1:0]             job_num_beats,
  output logic                          busy,
  output logic                          job_done,
  output logic                          err_early_done,
  output logic [BEAT_W-1:0]             beat_count,
  output logic                          params_vld,
  input  logic                          params_rdy,
  output logic [PARAM_W-1:0]            params_dat,
  output logic                          start_vld,
  input  logic                          start_rdy,
  input  logic                          done_vld,
  output logic                          done_rdy,
  input  logic                          mu_out_vld,
  output logic                          mu_out_rdy,
  output logic                          cgra_vld,
  input  logic                          cgra_rdy
);

  mu_seq_state_e     state_reg, state_next;
  logic [BEAT_W-1:0] num_beats_reg;
  logic [BEAT_W-1:0] beat_count_reg, beat_count_next;
  logic              err_reg, err_next;
  logic              job_done_reg, job_done_next;
  logic              capture, flush;
  logic              params_last, last_fire;
  logic              in_stream, beat, final_beat;

  mu_param_serializer #(
    .NUM_PARAMS (NUM_PARAMS),
    .PARAM_W    (PARAM_W)
  ) u_ser (
    .clk    (clk),
    .rstn   (rstn),
    .load   (capture),
    .flush  (flush),
    .par_in (job_params),
    .vld    (params_vld),
    .rdy    (params_rdy),
    .dat    (params_dat),
    .last   (params_last)
  );

  assign last_fire  = params_vld && params_rdy && params_last;
  assign in_stream  = (state_reg == STREAM);
  assign beat       = in_stream && mu_out_vld && cgra_rdy;
  assign final_beat = beat && (beat_count_reg == num_beats_reg - BEAT_W'(1));

  always_comb begin
    state_next      = state_reg;
    beat_count_next = beat_count_reg;
    err_next        = err_reg;
    job_done_next   = 1'b0;
    capture         = 1'b0;
    flush           = 1'b0;
    if (state_reg != IDLE && job_abort) begin
      state_next = IDLE;
      flush      = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (job_start) begin
            capture         = 1'b1;
            beat_count_next = '0;
            err_next        = 1'b0;
            state_next      = LOAD;
          end
        end
        LOAD: begin
          if (last_fire) state_next = START;
        end
        START: begin
          if (start_rdy) state_next = (num_beats_reg == '0) ? WAIT_DONE : STREAM;
        end
        STREAM: begin
          if (beat && beat_count_reg != '1) beat_count_next = beat_count_reg + BEAT_W'(1);
          // done coinciding with the final beat counts as a clean finish
          if (done_vld) begin
            state_next = IDLE;
            if (final_beat) job_done_next = 1'b1;
            else            err_next      = 1'b1;
          end else if (final_beat) begin
            state_next = WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (done_vld) begin
            state_next    = IDLE;
            job_done_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      num_beats_reg  <= '0;
      beat_count_reg <= '0;
      err_reg        <= 1'b0;
      job_done_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      beat_count_reg <= beat_count_next;
      err_reg        <= err_next;
      job_done_reg   <= job_done_next;
      if (capture) num_beats_reg <= job_num_beats;
    end
  end

  assign busy           = (state_reg != IDLE);
  assign job_done       = job_done_reg;
  assign err_early_done = err_reg;
  assign beat_count     = beat_count_reg;
  assign start_vld      = (state_reg == START);
  assign done_rdy       = in_stream || (state_reg == WAIT_DONE);
  assign cgra_vld       = in_stream && mu_out_vld;
  assign mu_out_rdy     = in_stream && cgra_rdy;

endmodule
